// File: rtl/mem_stage.sv
// mem_stage: EX->WB memory-access stage with RV32I branch resolution and a wait-state tolerant data-memory port.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses instead of forcing them aligned.
module mem_stage #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5,
  parameter int WB_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              stall_out,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              branch,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       store_data,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [WB_W-1:0]   wb_ctrl_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [3:0]        dmem_be,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              out_valid,
  output logic [31:0]       alu_out,
  output logic [31:0]       load_data,
  output logic [REG_W-1:0]  rd_out,
  output logic [WB_W-1:0]   wb_ctrl_out,
  output logic              branch_taken,
  output logic              misalign_err
);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  state_t r_state, w_next;
  size_t  w_size, r_size;

  logic              w_accept, w_ack, w_is_load, w_is_store, w_misalign, w_go_access, w_taken;
  logic [1:0]        w_off, r_off;
  logic [3:0]        w_be, r_be;
  logic [31:0]       w_wdata, r_wdata, w_lane, w_ld_ext;
  logic [ADDR_W-1:0] w_addr, r_addr;
  logic              r_we, r_ld, r_unsigned, r_out_valid, r_taken;
  logic [31:0]       r_alu_out, r_load_data;
  logic [REG_W-1:0]  r_rd;
  logic [WB_W-1:0]   r_wb;

  // Request decode from the EX-side inputs.
  // NOTE: every signal gets a default at the top of an always_comb so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_is_store = mem_write;
    w_is_load  = mem_read & ~mem_write;
    w_addr     = ADDR_W'(alu_result) & ~ADDR_W'(3);
    w_size     = SZ_WORD;
    w_off      = 2'b00;
    w_be       = 4'b1111;
    w_wdata    = store_data;
    w_misalign = 1'b0;
    w_taken    = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        w_size  = SZ_BYTE;
        w_off   = alu_result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_size  = SZ_HALF;
        w_off   = {alu_result[1], 1'b0};
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (w_is_store) begin
      case (w_size)
        SZ_BYTE: w_be = 4'b0001 << w_off;
        SZ_HALF: w_be = 4'b0011 << w_off;
        default: w_be = 4'b1111;
      endcase
    end
`ifdef MEM_MISALIGN_TRAP_EN
    w_misalign = (w_is_load | w_is_store) &
                 (((w_size == SZ_HALF) & alu_result[0]) |
                  ((w_size == SZ_WORD) & (alu_result[1:0] != 2'b00)));
`endif
    w_go_access = (w_is_load | w_is_store) & ~w_misalign;
    if (branch) begin
      case (funct3)
        3'b000:  w_taken = zero;
        3'b001:  w_taken = ~zero;
        3'b100:  w_taken = lt;
        3'b101:  w_taken = ~lt;
        3'b110:  w_taken = ltu;
        3'b111:  w_taken = ~ltu;
        default: w_taken = 1'b0;
      endcase
    end
  end

  // Next state and memory-port outputs; the port is driven only from captured request registers.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_ack      = 1'b0;
    stall_out  = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (r_state)
      IDLE: begin
        w_accept = in_valid;
        if (in_valid && w_go_access) w_next = ACCESS;
      end
      ACCESS: begin
        stall_out  = 1'b1;
        dmem_req   = 1'b1;
        dmem_we    = r_we;
        dmem_be    = r_be;
        dmem_addr  = r_addr;
        dmem_wdata = r_wdata;
        if (dmem_ack) begin
          w_ack  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_lane = dmem_rdata >> {r_off, 3'b000};
    case (r_size)
      SZ_BYTE: w_ld_ext = {{24{~r_unsigned & w_lane[7]}}, w_lane[7:0]};
      SZ_HALF: w_ld_ext = {{16{~r_unsigned & w_lane[15]}}, w_lane[15:0]};
      default: w_ld_ext = dmem_rdata;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_we <= 1'b0; r_be <= '0; r_addr <= '0; r_wdata <= '0;
      r_ld <= 1'b0; r_size <= SZ_WORD; r_off <= '0; r_unsigned <= 1'b0;
      r_out_valid <= 1'b0; r_alu_out <= '0; r_load_data <= '0;
      r_rd <= '0; r_wb <= '0; r_taken <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_accept) begin
        r_we        <= w_is_store;
        r_be        <= w_be;
        r_addr      <= w_addr;
        r_wdata     <= w_wdata;
        r_ld        <= w_is_load;
        r_size      <= w_size;
        r_off       <= w_off;
        r_unsigned  <= funct3[2];
        r_alu_out   <= alu_result;
        r_rd        <= rd_in;
        r_wb        <= wb_ctrl_in;
        r_taken     <= w_taken;
        r_load_data <= '0;
        r_out_valid <= ~w_go_access;
      end
      if (w_ack) begin
        r_out_valid <= 1'b1;
        if (r_ld) r_load_data <= w_ld_ext;
      end
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (!rst)          r_misalign <= 1'b0;
    else if (w_accept) r_misalign <= w_misalign;
  end
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign out_valid    = r_out_valid;
  assign alu_out      = r_alu_out;
  assign load_data    = r_load_data;
  assign rd_out       = r_rd;
  assign wb_ctrl_out  = r_wb;
  assign branch_taken = r_taken;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed and randomized checks of mem_stage against a behavioural model of the stage.
module tb_mem_stage;
  localparam int ADDR_W = 32;
  localparam int REG_W  = 5;
  localparam int WB_W   = 2;

  logic clk = 1'b0;
  logic rst, in_valid, stall_out, mem_read, mem_write, branch, zero, lt, ltu;
  logic [2:0] funct3;
  logic [31:0] alu_result, store_data, dmem_wdata, dmem_rdata, alu_out, load_data;
  logic [REG_W-1:0] rd_in, rd_out;
  logic [WB_W-1:0] wb_ctrl_in, wb_ctrl_out;
  logic dmem_req, dmem_we, dmem_ack, out_valid, branch_taken, misalign_err;
  logic [3:0] dmem_be;
  logic [ADDR_W-1:0] dmem_addr;

  int n_cmp = 0;
  int n_err = 0;

  mem_stage #(.ADDR_W(ADDR_W), .REG_W(REG_W), .WB_W(WB_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall_out(stall_out),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .funct3(funct3),
    .zero(zero), .lt(lt), .ltu(ltu), .alu_result(alu_result), .store_data(store_data),
    .rd_in(rd_in), .wb_ctrl_in(wb_ctrl_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_be(dmem_be), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .out_valid(out_valid),
    .alu_out(alu_out), .load_data(load_data), .rd_out(rd_out), .wb_ctrl_out(wb_ctrl_out),
    .branch_taken(branch_taken), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rd_, wr, br; logic [2:0] f3; logic z, l, lu;
    logic [31:0] addr, sdata; logic [4:0] rd; logic [1:0] wb;
  } instr_t;

  typedef struct {
    logic mem; logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
    logic [31:0] ld; logic taken; logic mis;
  } exp_t;

  typedef struct {
    logic req; logic [31:0] addr; logic [3:0] be; logic we; logic [31:0] wdata;
    int stall; int lat; logic [31:0] ld, alu; logic [4:0] rd; logic [1:0] wb;
    logic taken, mis, pulse_end;
  } obs_t;

  function automatic instr_t mk(logic r, logic w, logic b, logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    instr_t t;
    t.rd_ = r; t.wr = w; t.br = b; t.f3 = f3; t.addr = a; t.sdata = d;
    t.z = 1'b0; t.l = 1'b0; t.lu = 1'b0;
    t.rd = 5'($urandom); t.wb = 2'($urandom);
    return t;
  endfunction

  // Behavioural model: lane arithmetic on byte offsets rather than bit slicing.
  function automatic exp_t model(instr_t t, logic [31:0] rdata);
    exp_t e;
    int unsigned sz, a4, ofs;
    logic ld, st;
    longint unsigned v;
    st = t.wr;
    ld = t.rd_ && !t.wr;
    sz = (t.f3[1:0] == 2'b00) ? 1 : (t.f3[1:0] == 2'b01) ? 2 : 4;
    a4 = t.addr % 4;
    e.mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    if ((ld || st) && (a4 % sz) != 0) e.mis = 1'b1;
`endif
    e.mem   = (ld || st) && !e.mis;
    ofs     = (a4 / sz) * sz;
    e.addr  = t.addr - a4;
    e.we    = st;
    e.be    = ld ? 4'hF : 4'(((1 << sz) - 1) << ofs);
    e.wdata = (sz == 1) ? (t.sdata & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (t.sdata & 32'hFFFF) * 32'h00010001 : t.sdata;
    v = (64'(rdata) >> (8 * ofs)) & ((64'd1 << (8 * sz)) - 1);
    if (!t.f3[2] && sz < 4 && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    e.ld = (ld && e.mem) ? 32'(v) : 32'h0;
    case (t.f3)
      3'd0: e.taken = t.z;
      3'd1: e.taken = !t.z;
      3'd4: e.taken = t.l;
      3'd5: e.taken = !t.l;
      3'd6: e.taken = t.lu;
      3'd7: e.taken = !t.lu;
      default: e.taken = 1'b0;
    endcase
    e.taken = e.taken && t.br;
    return e;
  endfunction

  task automatic drive(instr_t t);
    in_valid = 1'b1; mem_read = t.rd_; mem_write = t.wr; branch = t.br; funct3 = t.f3;
    zero = t.z; lt = t.l; ltu = t.lu; alu_result = t.addr; store_data = t.sdata;
    rd_in = t.rd; wb_ctrl_in = t.wb;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0;
  endtask

  // Issues one instruction from IDLE; acks in cycle N+k; bounded wait for out_valid.
  task automatic issue(instr_t t, int k, logic [31:0] rdata, output obs_t o);
    drive(t);
    @(posedge clk); #1;
    idle_inputs();
    o.lat = 1; o.stall = 0;
    o.req = dmem_req; o.addr = dmem_addr; o.be = dmem_be; o.we = dmem_we; o.wdata = dmem_wdata;
    while (out_valid !== 1'b1 && o.lat < 20) begin
      if (stall_out === 1'b1) o.stall++;
      if (o.lat == k) begin dmem_ack = 1'b1; dmem_rdata = rdata; end
      @(posedge clk); #1;
      dmem_ack = 1'b0; o.lat++;
    end
    o.ld = load_data; o.alu = alu_out; o.rd = rd_out; o.wb = wb_ctrl_out;
    o.taken = branch_taken; o.mis = misalign_err;
    @(posedge clk); #1;
    o.pulse_end = out_valid;
  endtask

  task automatic test_reset();
    obs_t o;
    instr_t t;
    rst = 1'b0; idle_inputs(); dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({out_valid, stall_out, dmem_req, branch_taken, misalign_err} !== 5'b0)
      begin n_err++; $display("FAIL reset_ctrl: got %b want 00000", {out_valid, stall_out, dmem_req, branch_taken, misalign_err}); end
    n_cmp++; if ({load_data, alu_out} !== 64'h0)
      begin n_err++; $display("FAIL reset_data: got %h want 0", {load_data, alu_out}); end
    rst = 1'b1;
    @(posedge clk); #1;
    t = mk(1, 0, 0, 3'b010, 32'h200, 0);
    drive(t);
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rst_pre_req: got %b want 1", dmem_req); end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++; if ({dmem_req, stall_out, out_valid} !== 3'b000)
        begin n_err++; $display("FAIL rst_access: got %b want 000", {dmem_req, stall_out, out_valid}); end
    end
    rst = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if ({out_valid, dmem_req} !== 2'b00)
        begin n_err++; $display("FAIL late_ack: got %b want 00", {out_valid, dmem_req}); end
      @(posedge clk); #1;
    end
    issue(mk(0, 0, 0, 3'b000, 32'h7, 0), 1, 0, o);
    n_cmp++; if (o.lat !== 1) begin n_err++; $display("FAIL post_rst_alu_lat: got %0d want 1", o.lat); end
  endtask

  task automatic test_store_byte();
    obs_t o;
    issue(mk(0, 1, 0, 3'b000, 32'h103, 32'hAABBCCDD), 1, 0, o);
    n_cmp++; if (o.be !== 4'b1000) begin n_err++; $display("FAIL sb_be: got %b want 1000", o.be); end
    n_cmp++; if (o.wdata !== 32'hDDDDDDDD) begin n_err++; $display("FAIL sb_wdata: got %h want DDDDDDDD", o.wdata); end
    n_cmp++; if (o.addr !== 32'h100 || o.we !== 1'b1) begin n_err++; $display("FAIL sb_addr_we: got %h/%b want 100/1", o.addr, o.we); end
    n_cmp++; if (o.lat !== 2 || o.pulse_end !== 1'b0) begin n_err++; $display("FAIL sb_lat: got %0d/%b want 2/0", o.lat, o.pulse_end); end
  endtask

  task automatic test_load_ext();
    obs_t o;
    issue(mk(1, 0, 0, 3'b000, 32'h102, 0), 2, 32'h00800000, o);
    n_cmp++; if (o.ld !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb: got %h want FFFFFF80", o.ld); end
    issue(mk(1, 0, 0, 3'b100, 32'h102, 0), 1, 32'h00800000, o);
    n_cmp++; if (o.ld !== 32'h00000080) begin n_err++; $display("FAIL lbu: got %h want 00000080", o.ld); end
    issue(mk(1, 0, 0, 3'b101, 32'h102, 0), 1, 32'h80010000, o);
    n_cmp++; if (o.ld !== 32'h00008001) begin n_err++; $display("FAIL lhu: got %h want 00008001", o.ld); end
    n_cmp++; if (o.be !== 4'hF || o.we !== 1'b0) begin n_err++; $display("FAIL load_be: got %b/%b want 1111/0", o.be, o.we); end
  endtask

  task automatic test_back_to_back();
    int stall_cnt;
    drive(mk(1, 0, 0, 3'b010, 32'h400, 0));
    @(posedge clk); #1;
    drive(mk(1, 0, 0, 3'b010, 32'h800, 0));
    stall_cnt = 0;
    for (int c = 1; c <= 4; c++) begin
      if (stall_out === 1'b1) stall_cnt++;
      if (c == 4) begin
        n_cmp++; if (dmem_addr !== 32'h400) begin n_err++; $display("FAIL b2b_hold_addr: got %h want 400", dmem_addr); end
        dmem_ack = 1'b1; dmem_rdata = 32'hCAFEF00D;
      end
      @(posedge clk); #1;
      dmem_ack = 1'b0;
    end
    n_cmp++; if (stall_out !== 1'b0 || stall_cnt != 4) begin n_err++; $display("FAIL lw_stall: got %0d cycles want 4", stall_cnt); end
    n_cmp++; if (out_valid !== 1'b1 || load_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_first: got %b/%h want 1/CAFEF00D", out_valid, load_data); end
    @(posedge clk); #1;
    idle_inputs();
    n_cmp++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h800 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL b2b_second_req: got %b/%h/%b want 1/800/0", dmem_req, dmem_addr, out_valid); end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADBEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || load_data !== 32'h0BADBEEF) begin n_err++; $display("FAIL b2b_second: got %b/%h want 1/0BADBEEF", out_valid, load_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    obs_t o;
    instr_t t;
    logic [7:0] want = 8'b1001_0010;  // bit i = expected taken for funct3 i
    for (int f = 0; f < 8; f++) begin
      t = mk(0, 0, 1, 3'(f), 32'h10, 0);
      t.l = 1'b1;
      issue(t, 1, 0, o);
      n_cmp++; if (o.taken !== want[f] || o.lat !== 1) begin n_err++; $display("FAIL br_f3_%0d: got %b/%0d want %b/1", f, o.taken, o.lat, want[f]); end
      t.br = 1'b0;
      issue(t, 1, 0, o);
      n_cmp++; if (o.taken !== 1'b0) begin n_err++; $display("FAIL nobr_f3_%0d: got %b want 0", f, o.taken); end
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    issue(mk(1, 0, 0, 3'b010, 32'h102, 0), 1, 32'h11223344, o);
`ifdef MEM_MISALIGN_TRAP_EN
    n_cmp++; if (o.mis !== 1'b1 || o.req !== 1'b0 || o.lat !== 1 || o.ld !== 32'h0)
      begin n_err++; $display("FAIL lw_mis: got mis=%b req=%b lat=%0d ld=%h want 1/0/1/0", o.mis, o.req, o.lat, o.ld); end
`else
    n_cmp++; if (o.mis !== 1'b0 || o.addr !== 32'h100 || o.lat !== 2 || o.ld !== 32'h11223344)
      begin n_err++; $display("FAIL lw_align: got mis=%b addr=%h lat=%0d ld=%h want 0/100/2/11223344", o.mis, o.addr, o.lat, o.ld); end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    instr_t t;
    exp_t e;
    int k, kind;
    logic [31:0] rdata;
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 4);
      t = mk(kind == 1 || kind == 4, kind == 2 || kind == 4, kind == 3, 3'($urandom), $urandom(), $urandom());
      t.z = 1'($urandom); t.l = 1'($urandom); t.lu = 1'($urandom);
      k = $urandom_range(1, 4);
      rdata = $urandom();
      e = model(t, rdata);
      issue(t, k, rdata, o);
      n_cmp++; if (o.req !== e.mem) begin n_err++; $display("FAIL rnd%0d_req: got %b want %b", n, o.req, e.mem); end
      if (e.mem) begin
        n_cmp++; if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we)
          begin n_err++; $display("FAIL rnd%0d_port: got %h/%b/%b want %h/%b/%b", n, o.addr, o.be, o.we, e.addr, e.be, e.we); end
        if (e.we) begin
          n_cmp++; if (o.wdata !== e.wdata) begin n_err++; $display("FAIL rnd%0d_wdata: got %h want %h", n, o.wdata, e.wdata); end
        end
      end
      n_cmp++; if (o.lat !== (e.mem ? k + 1 : 1) || o.stall !== (e.mem ? k : 0))
        begin n_err++; $display("FAIL rnd%0d_timing: got lat=%0d stall=%0d want %0d/%0d", n, o.lat, o.stall, e.mem ? k + 1 : 1, e.mem ? k : 0); end
      n_cmp++; if (o.ld !== e.ld) begin n_err++; $display("FAIL rnd%0d_ld: got %h want %h", n, o.ld, e.ld); end
      n_cmp++; if (o.alu !== t.addr || o.rd !== t.rd || o.wb !== t.wb)
        begin n_err++; $display("FAIL rnd%0d_pass: got %h/%0d/%0d want %h/%0d/%0d", n, o.alu, o.rd, o.wb, t.addr, t.rd, t.wb); end
      n_cmp++; if (o.taken !== e.taken || o.mis !== e.mis || o.pulse_end !== 1'b0)
        begin n_err++; $display("FAIL rnd%0d_flags: got %b/%b/%b want %b/%b/0", n, o.taken, o.mis, o.pulse_end, e.taken, e.mis); end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_ext();
    test_back_to_back();
    test_branch();
    test_misalign();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
